// File: rtl/gon_pkg.sv
// Shared GON definitions: default geometry, the ID scan controller state type
// and the counter sizing helper.
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif

package gon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } gon_scan_state_e;

  // Bits needed to count 0..n inclusive.
  function automatic int gon_cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/gon_id_scan_ctrl.sv
// Streams CHAIN_LEN multicast-controller IDs into the GON scan chain, then
// verifies the chain by comparing its serial output against the first ID sent.
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif

module gon_id_scan_ctrl
  import gon_pkg::*;
#(
  parameter int CHAIN_LEN = `NUMS_PE_COL,
  parameter int ID_SIZE   = `XID_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_valid,
  input  logic [ID_SIZE-1:0] cfg_id,
  output logic               cfg_ready,
  output logic               set_id,
  output logic [ID_SIZE-1:0] ID_scan_in,
  input  logic [ID_SIZE-1:0] ID_scan_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int               CNT_W    = gon_cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);

  gon_scan_state_e    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_SIZE-1:0] first_id_q, first_id_d;
  logic [ID_SIZE-1:0] scan_in_q, scan_in_d;
  logic               set_id_q, set_id_d;
  logic               err_q, err_d;
  logic               accept;

  assign accept = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
        else       state_d = IDLE;
      end
      LOAD: begin
        if (accept && (cnt_q == CNT_LAST)) state_d = FLUSH;
        else                               state_d = LOAD;
      end
      FLUSH:   state_d = CHECK;
      CHECK:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE:    busy      = 1'b0;
      LOAD:    cfg_ready = 1'b1;
      DONE:    done      = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  // Each accept becomes a registered shift pulse on the following cycle.
  always_comb begin
    cnt_d      = cnt_q;
    first_id_d = first_id_q;
    scan_in_d  = scan_in_q;
    set_id_d   = 1'b0;
    err_d      = err_q;
    if ((state_q == IDLE) && start) begin
      cnt_d = {CNT_W{1'b0}};
      err_d = 1'b0;
    end else if (accept) begin
      set_id_d  = 1'b1;
      scan_in_d = cfg_id;
      if (cnt_q == {CNT_W{1'b0}}) first_id_d = cfg_id;
      else                        first_id_d = first_id_q;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else                  cnt_d = cnt_q;
    end else if (state_q == CHECK) begin
      // The final shift has landed, so the chain tail now holds the first ID.
      err_d = (ID_scan_out != first_id_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= {CNT_W{1'b0}};
      first_id_q <= {ID_SIZE{1'b0}};
      scan_in_q  <= {ID_SIZE{1'b0}};
      set_id_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      first_id_q <= first_id_d;
      scan_in_q  <= scan_in_d;
      set_id_q   <= set_id_d;
      err_q      <= err_d;
    end
  end

  assign set_id     = set_id_q;
  assign ID_scan_in = scan_in_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gon_id_scan_ctrl.sv
// Directed bench for gon_id_scan_ctrl with a behavioural scan-chain model;
// covers CHAIN_LEN=8 and CHAIN_LEN=1 instances.
module tb_gon_id_scan_ctrl;
  import gon_pkg::*;

  localparam int CL = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, cfg_valid, fault;
  logic [IW-1:0] cfg_id, scan_out;
  logic          cfg_ready, set_id, busy, done, err;
  logic [IW-1:0] scan_in;
  logic [IW-1:0] mc [CL];

  logic          start1, cfg_valid1;
  logic [IW-1:0] cfg_id1, scan_out1, scan_in1, mc1;
  logic          ready1, set1, busy1, done1, err1;

  int n_total = 0;
  int n_bad   = 0;

  gon_id_scan_ctrl #(.CHAIN_LEN(CL), .ID_SIZE(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_valid(cfg_valid), .cfg_id(cfg_id),
    .cfg_ready(cfg_ready), .set_id(set_id), .ID_scan_in(scan_in),
    .ID_scan_out(scan_out), .busy(busy), .done(done), .err(err)
  );

  gon_id_scan_ctrl #(.CHAIN_LEN(1), .ID_SIZE(IW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_valid(cfg_valid1), .cfg_id(cfg_id1),
    .cfg_ready(ready1), .set_id(set1), .ID_scan_in(scan_in1),
    .ID_scan_out(scan_out1), .busy(busy1), .done(done1), .err(err1)
  );

  // Chain model: MC 0 takes the serial input, the last MC drives the readback.
  always @(posedge clk) begin
    if (set_id) begin
      mc[0] <= scan_in;
      for (int i = 1; i < CL; i++) mc[i] <= mc[i-1];
    end
    if (set1) mc1 <= scan_in1;
  end
  assign scan_out  = fault ? {IW{1'b0}} : mc[CL-1];
  assign scan_out1 = mc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", 32'(dut.state_q), 32'(LOAD));
    chk("start_ready", 32'(cfg_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err", 32'(err), 32'd0);
  endtask

  task automatic accept(input logic [IW-1:0] id);
    cfg_valid = 1'b1;
    cfg_id    = id;
    tick();
    cfg_valid = 1'b0;
    chk("acc_set_id", 32'(set_id), 32'd1);
    chk("acc_scan_in", 32'(scan_in), 32'(id));
  endtask

  task automatic stall_cycle(input logic [IW-1:0] last_id);
    tick();
    chk("stall_set_id", 32'(set_id), 32'd0);
    chk("stall_scan_in", 32'(scan_in), 32'(last_id));
  endtask

  // Called right after the last accept edge: FLUSH now, CHECK, DONE, IDLE.
  task automatic tail(input logic exp_err);
    chk("flush_state", 32'(dut.state_q), 32'(FLUSH));
    chk("flush_ready", 32'(cfg_ready), 32'd0);
    tick();
    chk("check_state", 32'(dut.state_q), 32'(CHECK));
    chk("check_set_id", 32'(set_id), 32'd0);
    chk("check_done", 32'(done), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'(exp_err));
    chk("done_busy", 32'(busy), 32'd1);
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_err", 32'(err), 32'(exp_err));
  endtask

  task automatic full_pass(input logic [IW-1:0] base, input int gap, input logic exp_err);
    logic [IW-1:0] id;
    do_start();
    for (int k = 0; k < CL; k++) begin
      id = base + IW'(k);
      accept(id);
      if (k < CL - 1) for (int g = 0; g < gap; g++) stall_cycle(id);
    end
    tail(exp_err);
  endtask

  task automatic chk_chain();
    for (int i = 0; i < CL; i++) chk("chain_mc", 32'(mc[i]), 32'(CL - i));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_id = {IW{1'b0}}; fault = 1'b0;
    start1 = 1'b0; cfg_valid1 = 1'b0; cfg_id1 = {IW{1'b0}};

    repeat (3) tick();
    for (int r = 0; r < 2; r++) begin
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_set_id", 32'(set_id), 32'd0);
      chk("rst_scan_in", 32'(scan_in), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      rst = 1'b1;
      if (r == 0) repeat (2) tick();
    end

    full_pass(4'd1, 0, 1'b0);
    chk_chain();

    full_pass(4'd1, 2, 1'b0);
    chk_chain();

    fault = 1'b1;
    full_pass(4'd5, 0, 1'b1);
    chk("fault_first_id", 32'(dut.first_id_q), 32'd5);
    repeat (2) tick();
    chk("fault_err_held", 32'(err), 32'd1);
    fault = 1'b0;

    // Start during LOAD must not restart or count.
    do_start();
    accept(4'd1);
    accept(4'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_cnt", 32'(dut.cnt_q), 32'd2);
    chk("ign_start_state", 32'(dut.state_q), 32'(LOAD));
    chk("ign_start_set_id", 32'(set_id), 32'd0);
    for (int k = 3; k <= CL; k++) accept(IW'(k));
    tail(1'b0);
    chk_chain();

    cfg_valid = 1'b1;
    cfg_id    = 4'd7;
    repeat (2) tick();
    chk("ign_valid_state", 32'(dut.state_q), 32'(IDLE));
    chk("ign_valid_cnt", 32'(dut.cnt_q), 32'(CL));
    chk("ign_valid_set_id", 32'(set_id), 32'd0);
    chk("ign_valid_scan_in", 32'(scan_in), 32'(CL));
    cfg_valid = 1'b0;

    do_start();
    accept(4'd1);
    accept(4'd2);
    accept(4'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cnt", 32'(dut.cnt_q), 32'd0);
    chk("abort_scan_in", 32'(scan_in), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    full_pass(4'd1, 0, 1'b0);
    chk_chain();

    // Single-element chain: one accept goes straight to FLUSH.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("cl1_ready", 32'(ready1), 32'd1);
    cfg_valid1 = 1'b1;
    cfg_id1    = 4'd9;
    tick();
    cfg_valid1 = 1'b0;
    chk("cl1_set_id", 32'(set1), 32'd1);
    chk("cl1_scan_in", 32'(scan_in1), 32'd9);
    chk("cl1_flush", 32'(dut1.state_q), 32'(FLUSH));
    chk("cl1_ready_off", 32'(ready1), 32'd0);
    repeat (2) tick();
    chk("cl1_done", 32'(done1), 32'd1);
    chk("cl1_err", 32'(err1), 32'd0);
    tick();
    chk("cl1_idle", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
